// File: rtl/mem_line_ctrl.sv
// Line-granular main-memory model on the C2/A2/D2 bus: whole-line READ/WRITE bursts, first RESPONSE LATENCY cycles after the command edge, busy blocks new commands.
// Define MEM_LINE_CTRL_STATS_EN to add saturating rd_count/wr_count request counters.
module mem_line_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int LINE_BYTES = 16,
    parameter int BUS_BYTES  = 2,
    parameter int LATENCY    = 100,
    parameter logic [7:0] SEED = 8'h5A
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             c2_in,
    input  logic [ADDR_W-1:0]      a2_in,
    input  logic [8*BUS_BYTES-1:0] d2_in,
    output logic [1:0]             c2_out,
    output logic                   c2_oe,
    output logic [8*BUS_BYTES-1:0] d2_out,
    output logic                   d2_oe,
    output logic                   busy
`ifdef MEM_LINE_CTRL_STATS_EN
    ,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`endif
);

    localparam int BEATS = LINE_BYTES / BUS_BYTES;
    localparam int BW    = 8 * BUS_BYTES;
    localparam int LW    = 8 * LINE_BYTES;
    localparam int CW    = $clog2(LATENCY + 1);
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] CMD_RESPONSE = 2'b01;
    localparam logic [1:0] CMD_READ     = 2'b10;
    localparam logic [1:0] CMD_WRITE    = 2'b11;

    typedef enum logic [1:0] {IDLE, WCOL, WAIT, RESP} state_t;

    state_t             state;
    logic [CW-1:0]      lat_cnt;
    logic [BCW-1:0]     bidx;
    logic [ADDR_W-1:0]  addr_q;
    logic               is_wr;
    logic [LW-1:0]      wbuf;
    logic [LW-1:0]      wline;
    logic [LW-1:0]      rline;

    logic [LW-1:0]      mem [DEPTH];
    // Lines never written read back the power-up fill pattern.
    logic               written [DEPTH];

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [LW-1:0]      mem_wdata;

    function automatic logic [LW-1:0] fill_line(input logic [ADDR_W-1:0] a);
        logic [LW-1:0] l;
        l = '0;
        for (int b = 0; b < LINE_BYTES; b++)
            l[8*b +: 8] = 8'(int'(a) * LINE_BYTES + b) ^ SEED;
        return l;
    endfunction

    always_comb begin
        rline = written[addr_q] ? mem[addr_q] : fill_line(addr_q);
    end

    always_comb begin
        wline = wbuf;
        if (state == WCOL)
            wline[bidx*BW +: BW] = d2_in;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wline;
        if (state == WCOL && bidx == BCW'(BEATS - 1)) begin
            mem_we = 1'b1;
        end else if (BEATS == 1 && state == IDLE && c2_in == CMD_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = a2_in;
            mem_wdata = LW'(d2_in);
        end
        mem_we = mem_we & ~reset;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr]     <= mem_wdata;
            written[mem_waddr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            c2_out  <= 2'b00;
            c2_oe   <= 1'b0;
            d2_out  <= '0;
            d2_oe   <= 1'b0;
            busy    <= 1'b0;
            lat_cnt <= '0;
            bidx    <= '0;
            addr_q  <= '0;
            is_wr   <= 1'b0;
            wbuf    <= '0;
`ifdef MEM_LINE_CTRL_STATS_EN
            rd_count <= '0;
            wr_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (c2_in == CMD_READ || c2_in == CMD_WRITE) begin
                        addr_q       <= a2_in;
                        lat_cnt      <= CW'(LATENCY);
                        busy         <= 1'b1;
                        is_wr        <= (c2_in == CMD_WRITE);
                        wbuf[BW-1:0] <= d2_in;
                        bidx         <= BCW'(1);
                        if (c2_in == CMD_WRITE && BEATS > 1)
                            state <= WCOL;
                        else
                            state <= WAIT;
`ifdef MEM_LINE_CTRL_STATS_EN
                        if (c2_in == CMD_READ && rd_count != 16'hFFFF)
                            rd_count <= rd_count + 16'd1;
                        if (c2_in == CMD_WRITE && wr_count != 16'hFFFF)
                            wr_count <= wr_count + 16'd1;
`endif
                    end
                end
                WCOL: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    wbuf    <= wline;
                    if (bidx == BCW'(BEATS - 1)) begin
                        bidx  <= '0;
                        state <= WAIT;
                    end else begin
                        bidx <= bidx + 1'b1;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    // Counter loaded with LATENCY reaches 1 exactly on edge LATENCY.
                    if (lat_cnt == CW'(1)) begin
                        state  <= RESP;
                        c2_oe  <= 1'b1;
                        c2_out <= CMD_RESPONSE;
                        bidx   <= BCW'(1);
                        if (!is_wr) begin
                            d2_oe  <= 1'b1;
                            d2_out <= rline[BW-1:0];
                        end
                    end
                end
                RESP: begin
                    if (is_wr || bidx == BCW'(BEATS)) begin
                        state  <= IDLE;
                        c2_oe  <= 1'b0;
                        c2_out <= 2'b00;
                        d2_oe  <= 1'b0;
                        d2_out <= '0;
                        busy   <= 1'b0;
                        bidx   <= '0;
                    end else begin
                        d2_out <= rline[bidx*BW +: BW];
                        bidx   <= bidx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl: default instance plus a single-beat, short-latency instance.
module tb_mem_line_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  c2_in;
    logic [13:0] a2_in;
    logic [15:0] d2_in;
    logic [1:0]  c2_out;
    logic        c2_oe;
    logic [15:0] d2_out;
    logic        d2_oe;
    logic        busy;

    logic [1:0]  c2_in5;
    logic [13:0] a2_in5;
    logic [63:0] d2_in5;
    logic [1:0]  c2_out5;
    logic        c2_oe5;
    logic [63:0] d2_out5;
    logic        d2_oe5;
    logic        busy5;

`ifdef MEM_LINE_CTRL_STATS_EN
    logic [15:0] rd_count, wr_count, rd_count5, wr_count5;
`endif

    mem_line_ctrl dut (
        .clk(clk), .reset(reset), .c2_in(c2_in), .a2_in(a2_in), .d2_in(d2_in),
        .c2_out(c2_out), .c2_oe(c2_oe), .d2_out(d2_out), .d2_oe(d2_oe), .busy(busy)
`ifdef MEM_LINE_CTRL_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    mem_line_ctrl #(.LINE_BYTES(8), .BUS_BYTES(8), .LATENCY(5)) dut5 (
        .clk(clk), .reset(reset), .c2_in(c2_in5), .a2_in(a2_in5), .d2_in(d2_in5),
        .c2_out(c2_out5), .c2_oe(c2_oe5), .d2_out(d2_out5), .d2_oe(d2_oe5), .busy(busy5)
`ifdef MEM_LINE_CTRL_STATS_EN
        , .rd_count(rd_count5), .wr_count(wr_count5)
`endif
    );

    typedef struct packed {
        int          cyc;
        logic [15:0] dat;
        logic        rd;
    } exp_t;

    exp_t         sbq[$];
    exp_t         e;
    logic [127:0] mdl [int];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           t0 = 0;
    int           n_rd = 0;
    int           n_wr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] fill_line(input int a);
        logic [127:0] l;
        for (int b = 0; b < 16; b++)
            l[b*8 +: 8] = 8'((a * 16 + b) & 255) ^ 8'h5A;
        return l;
    endfunction

    function automatic logic [127:0] get_line(input int a);
        return mdl.exists(a) ? mdl[a] : fill_line(a);
    endfunction

    // Every RESPONSE cycle pops one expectation; a quiet bus must be fully idle.
    always @(negedge clk) begin
        if (!reset) begin
            if (c2_oe) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 64'(c2_oe), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("c2_out", 64'(c2_out), 64'h1);
                    chk("d2_oe", 64'(d2_oe), 64'(e.rd));
                    chk("d2_out", 64'(d2_out), e.rd ? 64'(e.dat) : 64'd0);
                end
            end else begin
                chk("idle_bus", 64'({c2_out, d2_oe, d2_out}), 64'd0);
                if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                    chk("missed_resp", 64'(cyc), 64'(sbq[0].cyc));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        #2;
        sbq.delete();
        reset = 1'b1;
        n_rd = 0;
        n_wr = 0;
        #1;
        chk("rst_outputs", 64'({c2_out, c2_oe, d2_out, d2_oe, busy}), 64'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input int a, input bit acc);
        logic [127:0] l;
        c2_in = 2'b10;
        a2_in = 14'(a);
        if (acc) begin
            t0 = cyc + 1;
            n_rd++;
            l = get_line(a);
            for (int k = 0; k < 8; k++)
                sbq.push_back('{cyc: t0 + 100 + k, dat: l[k*16 +: 16], rd: 1'b1});
        end
        @(negedge clk);
        c2_in = 2'b00;
    endtask

    task automatic do_write(input int a, input logic [127:0] l, input int abort_after);
        c2_in = 2'b11;
        a2_in = 14'(a);
        d2_in = l[15:0];
        t0 = cyc + 1;
        n_wr++;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            c2_in = 2'b00;
            if (abort_after >= 0 && k > abort_after) begin
                d2_in = '0;
                do_reset();
                return;
            end
            d2_in = l[k*16 +: 16];
        end
        @(negedge clk);
        d2_in = '0;
        mdl[a] = l;
        sbq.push_back('{cyc: t0 + 100, dat: 16'h0, rd: 1'b0});
    endtask

    task automatic wait_rel(input int r);
        while (cyc < t0 + r) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] l;
        logic [63:0]  w5;
        int           ra;
        int           s5;

        reset = 1'b1;
        c2_in = '0; a2_in = '0; d2_in = '0;
        c2_in5 = '0; a2_in5 = '0; d2_in5 = '0;
        #3;
        chk("reset_state", 64'({c2_out, c2_oe, d2_out, d2_oe, busy}), 64'd0);
        chk("reset_state5", 64'({c2_out5, c2_oe5, d2_oe5, busy5}), 64'd0);
        chk("reset_d2_5", d2_out5, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single-beat instance: read fill, then write/readback through the one-beat commit path.
        c2_in5 = 2'b10; a2_in5 = 14'd0; s5 = cyc + 1;
        @(negedge clk); c2_in5 = 2'b00;
        while (cyc < s5 + 4) @(negedge clk);
        chk("b1_early", 64'(c2_oe5), 64'd0);
        @(negedge clk);
        chk("b1_resp", 64'({c2_oe5, c2_out5, d2_oe5}), 64'b1011);
        chk("b1_data", d2_out5, 64'h5D5C5F5E59585B5A);
        @(negedge clk);
        chk("b1_done", 64'({c2_oe5, d2_oe5, busy5, c2_out5}), 64'd0);
        w5 = 64'h0123456789ABCDEF;
        c2_in5 = 2'b11; a2_in5 = 14'd3; d2_in5 = w5; s5 = cyc + 1;
        @(negedge clk); c2_in5 = 2'b00; d2_in5 = '0;
        while (cyc < s5 + 5) @(negedge clk);
        chk("b1_wr_resp", 64'({c2_oe5, c2_out5, d2_oe5}), 64'b1010);
        chk("b1_wr_d2", d2_out5, 64'd0);
        repeat (2) @(negedge clk);
        c2_in5 = 2'b10; a2_in5 = 14'd3; s5 = cyc + 1;
        @(negedge clk); c2_in5 = 2'b00;
        while (cyc < s5 + 5) @(negedge clk);
        chk("b1_rd_back", d2_out5, w5);

        // Fill read of line 3.
        do_read(3, 1);
        wait_rel(99);
        chk("t1_pre_resp", 64'(c2_oe), 64'd0);
        @(negedge clk);
        chk("t1_beat0", 64'(d2_out), 64'h6B6A);
        wait_idle();

        // Write line 5 with a byte-index pattern, then read it back.
        for (int b = 0; b < 16; b++) l[b*8 +: 8] = 8'(b);
        do_write(5, l, -1);
        wait_rel(100);
        chk("t2_wr_resp", 64'({c2_oe, d2_oe}), 64'b10);
        wait_idle();
        do_read(5, 1);
        wait_idle();

        // Reset during a read burst drops the bus at once.
        do_read(10, 1);
        wait_rel(103);
        chk("mr_active", 64'(d2_oe), 64'd1);
        do_reset();

        // Reset after beat 3 of a write leaves line 7 untouched.
        do_write(7, 128'hFFEEDDCCBBAA99887766554433221100, 3);
        do_read(7, 1);
        wait_rel(100);
        chk("t4_byte0", 64'(d2_out[7:0]), 64'h2A);
        wait_idle();

        // Reset while waiting after commit: no RESPONSE, data kept.
        do_write(9, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, -1);
        wait_rel(50);
        do_reset();
        do_read(9, 1);
        wait_idle();

        // READ while busy is ignored.
        do_read(1, 1);
        wait_rel(50);
        do_read(2, 0);
        chk("t3_busy_mid", 64'(busy), 64'd1);
        wait_rel(107);
        chk("t3_busy_end", 64'(busy), 64'd1);
        wait_idle();

        // Command in the last RESP cycle is dropped; the next cycle's is taken.
        do_read(4, 1);
        wait_rel(107);
        do_read(6, 0);
        chk("edge_busy_low", 64'(busy), 64'd0);
        do_read(8, 1);
        wait_idle();

        ra = int'($urandom_range(100, 16383));
        l = {$urandom, $urandom, $urandom, $urandom};
        do_write(ra, l, -1);
        wait_idle();
        do_read(ra, 1);
        wait_idle();

`ifdef MEM_LINE_CTRL_STATS_EN
        chk("rd_count", 64'(rd_count), 64'(n_rd));
        chk("wr_count", 64'(wr_count), 64'(n_wr));
        do_reset();
        chk("rd_count_rst", 64'(rd_count), 64'd0);
        chk("wr_count_rst", 64'(wr_count), 64'd0);
`endif

        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
